// File: rtl/snake_move_control.sv
// rtl/snake_move_control.sv - snake movement, growth and collision control
module snake_move_control #(
  parameter int MOVE_PERIOD = 2500000,
  parameter int STEP        = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [3:0]   Dir_Key,
  input  logic         Start,
  input  logic         Food_Eaten,
  output logic [175:0] Seg_X,
  output logic [175:0] Seg_Y,
  output logic [15:0]  Seg_En,
  output logic         Game_Over,
  output logic         Move_Tick
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic [1:0]  D_UP      = 2'd0;
  localparam logic [1:0]  D_DOWN    = 2'd1;
  localparam logic [1:0]  D_LEFT    = 2'd2;
  localparam logic [1:0]  D_RIGHT   = 2'd3;
  localparam logic [23:0] LAST_TICK = 24'(MOVE_PERIOD - 1);
  localparam logic [10:0] STEP_PX   = 11'(STEP);
  localparam logic [10:0] X_MIN     = 11'd20;
  localparam logic [10:0] X_MAX     = 11'd280;
  localparam logic [10:0] Y_MIN     = 11'd20;
  localparam logic [10:0] Y_MAX     = 11'd290;
  localparam logic [10:0] INIT_Y    = 11'd100;
  localparam logic [4:0]  INIT_LEN  = 5'd3;
  localparam logic [4:0]  MAX_LEN   = 5'd16;

  function automatic logic [10:0] init_x(input int k);
    return (k < 3) ? 11'(100 - 10 * k) : 11'd80;
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [10:0] r_x [16];
  logic [10:0] r_y [16];
  logic [4:0]  r_len;
  logic [4:0]  w_len_next;
  logic [1:0]  r_dir;
  logic [1:0]  r_pend;
  logic [1:0]  w_key_dir;
  logic [1:0]  w_ref_dir;
  logic [23:0] r_timer;
  logic        r_grow;
  logic        r_tick;
  logic        r_over;
  logic [15:0] r_en;
  logic [15:0] w_en_next;
  logic        w_start_run;
  logic        w_move;
  logic        w_key_ok;
  logic        w_hit_wall;
  logic        w_hit_body;
  logic        w_hit;
  logic        w_step;
  logic        w_grow_now;
  logic [10:0] w_nx;
  logic [10:0] w_ny;

  assign w_start_run = ((r_state == S_IDLE) || (r_state == S_OVER)) && Start;
  assign w_move      = (r_state == S_RUN) && (r_timer == LAST_TICK);

  always_comb begin
    w_key_dir = D_RIGHT;
    if (Dir_Key[3])      w_key_dir = D_UP;
    else if (Dir_Key[2]) w_key_dir = D_DOWN;
    else if (Dir_Key[1]) w_key_dir = D_LEFT;
  end

  // Reversal is judged against the direction in force after this edge, so the
  // pending direction can never be the opposite of the applied one.
  assign w_ref_dir = w_move ? r_pend : r_dir;
  assign w_key_ok  = (|Dir_Key) && (w_key_dir != (w_ref_dir ^ 2'b01));

  always_comb begin
    w_nx = r_x[0];
    w_ny = r_y[0];
    case (r_pend)
      D_UP:    w_ny = r_y[0] - STEP_PX;
      D_DOWN:  w_ny = r_y[0] + STEP_PX;
      D_LEFT:  w_nx = r_x[0] - STEP_PX;
      default: w_nx = r_x[0] + STEP_PX;
    endcase
  end

  assign w_hit_wall = (w_nx < X_MIN) || (w_nx > X_MAX) || (w_ny < Y_MIN) || (w_ny > Y_MAX);

  // The tail segment vacates its cell on this move, so only k <= length-2 counts.
  always_comb begin
    w_hit_body = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if ((r_x[k] == w_nx) && (r_y[k] == w_ny) && ((5'(k) + 5'd2) <= r_len))
        w_hit_body = 1'b1;
    end
  end

  assign w_hit      = w_hit_wall || w_hit_body;
  assign w_step     = w_move && !w_hit;
  assign w_grow_now = r_grow || Food_Eaten;
  assign w_len_next = (w_step && w_grow_now && (r_len != MAX_LEN)) ? r_len + 5'd1 : r_len;

  always_comb begin
    w_en_next = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      w_en_next[k] = (5'(k) < w_len_next);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_next_state = S_RUN;
      S_RUN:   if (w_move && w_hit) w_next_state = S_OVER;
      S_OVER:  if (Start) w_next_state = S_RUN;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < 16; k++) begin
        r_x[k] <= init_x(k);
        r_y[k] <= INIT_Y;
      end
      r_len   <= INIT_LEN;
      r_dir   <= D_RIGHT;
      r_pend  <= D_RIGHT;
      r_timer <= 24'd0;
      r_grow  <= 1'b0;
      r_tick  <= 1'b0;
      r_over  <= 1'b0;
      r_en    <= 16'h0000;
    end else begin
      r_tick <= w_step;
      r_over <= (w_next_state == S_OVER);
      if (w_start_run) begin
        for (int k = 0; k < 16; k++) begin
          r_x[k] <= init_x(k);
          r_y[k] <= INIT_Y;
        end
        r_len   <= INIT_LEN;
        r_dir   <= D_RIGHT;
        r_pend  <= D_RIGHT;
        r_timer <= 24'd0;
        r_grow  <= 1'b0;
        r_en    <= 16'h0007;
      end else if (r_state == S_RUN) begin
        r_timer <= w_move ? 24'd0 : r_timer + 24'd1;
        if (w_key_ok) r_pend <= w_key_dir;
        if (w_step) begin
          for (int k = 15; k > 0; k--) begin
            r_x[k] <= r_x[k-1];
            r_y[k] <= r_y[k-1];
          end
          r_x[0] <= w_nx;
          r_y[0] <= w_ny;
          r_dir  <= r_pend;
          if (w_grow_now) r_grow <= 1'b0;
        end else if (Food_Eaten) begin
          r_grow <= 1'b1;
        end
        r_len <= w_len_next;
        r_en  <= w_en_next;
      end else begin
        r_timer <= 24'd0;
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign Seg_X[11*g +: 11] = r_x[g];
    assign Seg_Y[11*g +: 11] = r_y[g];
  end

  assign Seg_En    = r_en;
  assign Game_Over = r_over;
  assign Move_Tick = r_tick;

endmodule
